// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART serial receiver.
// Build option: define SPART_PARITY_EN to add an even-parity bit after data bit 7.
package spart_pkg;

   localparam int SPART_BYTES_PER_WORD = 4;
   localparam int SPART_DATA_BITS      = 8;

   // Byte-level receive FSM states; PARITY only exists when parity is built in
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef SPART_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_e;

endpackage

// File: rtl/spart_rx_byte.sv
// Byte receiver: two-flop synchronizer, single baud counter and byte FSM.
// byte_valid_o / byte_err_o are decodes of the stop-bit sample point, so the
// word logic downstream registers them on the very edge the stop bit is taken.
// Build option: SPART_PARITY_EN inserts a PARITY state (even parity).
module spart_rx_byte
   import spart_pkg::*;
#(
   parameter int DIV = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       rx_i,
   output logic                       byte_valid_o,
   output logic [SPART_DATA_BITS-1:0] byte_data_o,
   output logic                       byte_err_o
);

   localparam int              CNT_W    = $clog2(DIV);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);
   localparam logic [2:0]       LAST_BIT = 3'(SPART_DATA_BITS - 1);

   logic [1:0]                 sync_q;
   logic                       rx_s;
   state_e                     state_q;
   logic [CNT_W-1:0]           baud_cnt_q;
   logic [2:0]                 bit_idx_q;
   logic [SPART_DATA_BITS-1:0] shift_q;
   logic                       full_hit;
   logic                       stop_hit;
   logic                       frame_ok;
`ifdef SPART_PARITY_EN
   logic                       parity_ok_q;
`endif

   assign rx_s     = sync_q[1];
   assign full_hit = (baud_cnt_q == FULL_M1);

   // Synchronize the asynchronous serial line into the clock domain
   always_ff @(posedge clk_i) begin
      // NOTE: reset the flops to the idle-high line level so release never looks like a start bit.
      if (rst_i) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], rx_i};
   end

   // Byte FSM: every state is timed by baud_cnt_q, sampling at mid-bit
   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      if (rst_i) begin
         state_q     <= ST_IDLE;
         baud_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
`ifdef SPART_PARITY_EN
         parity_ok_q <= 1'b1;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               baud_cnt_q <= '0;
               if (!rx_s) state_q <= ST_START;
            end
            ST_START: begin
               if (baud_cnt_q == HALF_M1) begin
                  baud_cnt_q <= '0;
                  bit_idx_q  <= '0;
                  state_q    <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (full_hit) begin
                  baud_cnt_q <= '0;
                  shift_q    <= {rx_s, shift_q[SPART_DATA_BITS-1:1]};
                  bit_idx_q  <= bit_idx_q + 1'b1;
                  if (bit_idx_q == LAST_BIT) begin
`ifdef SPART_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
`ifdef SPART_PARITY_EN
            ST_PARITY: begin
               if (full_hit) begin
                  baud_cnt_q  <= '0;
                  parity_ok_q <= (rx_s == (^shift_q));
                  state_q     <= ST_STOP;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (full_hit) begin
                  baud_cnt_q <= '0;
                  state_q    <= ST_IDLE;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
            default: begin
               baud_cnt_q <= '0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SPART_PARITY_EN
   assign frame_ok = rx_s & parity_ok_q;
`else
   assign frame_ok = rx_s;
`endif

   assign stop_hit     = (state_q == ST_STOP) && full_hit;
   assign byte_valid_o = stop_hit && frame_ok;
   assign byte_err_o   = stop_hit && !frame_ok;
   assign byte_data_o  = shift_q;

endmodule

// File: rtl/spart_rx.sv
// SPART receiver top: collects four accepted bytes little-endian into a word,
// raises word_irq / word_pending, tracks overrun and reports framing errors.
// Build option: SPART_PARITY_EN (even parity, handled in spart_rx_byte).
module spart_rx
   import spart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115_200
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        rx,
   input  logic        data_ack,
   output logic        word_irq,
   output logic [31:0] word_data,
   output logic        word_pending,
   output logic        overrun,
   output logic        frame_err
);

   localparam int         DIV      = CLK_HZ / BAUD;
   localparam int         ACC_W    = (SPART_BYTES_PER_WORD - 1) * SPART_DATA_BITS;
   localparam logic [1:0] LAST_IDX = 2'(SPART_BYTES_PER_WORD - 1);

   logic                       byte_valid;
   logic [SPART_DATA_BITS-1:0] byte_data;
   logic                       byte_err;

   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [31:0]      word_data_q, word_data_d;
   logic             word_irq_q, word_irq_d;
   logic             pending_q, pending_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;

   spart_rx_byte #(.DIV(DIV)) u_byte (
      .clk_i        (sys_clk),
      .rst_i        (rst),
      .rx_i         (rx),
      .byte_valid_o (byte_valid),
      .byte_data_o  (byte_data),
      .byte_err_o   (byte_err)
   );

   // Word assembly and flag next-state; partial bytes stay in acc_q only
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      byte_idx_d  = byte_idx_q;
      acc_d       = acc_q;
      word_data_d = word_data_q;
      word_irq_d  = 1'b0;
      pending_d   = pending_q;
      overrun_d   = overrun_q;
      frame_err_d = byte_err;

      if (data_ack) pending_d = 1'b0;

      if (byte_err) begin
         byte_idx_d = '0;
      end else if (byte_valid) begin
         acc_d      = {byte_data, acc_q[ACC_W-1:SPART_DATA_BITS]};
         byte_idx_d = byte_idx_q + 1'b1;
         if (byte_idx_q == LAST_IDX) begin
            word_data_d = {byte_data, acc_q};
            word_irq_d  = 1'b1;
            pending_d   = 1'b1;
            // an ack landing on the completion edge consumes the old word first
            if (pending_q && !data_ack) overrun_d = 1'b1;
         end
      end
   end

   // Register word state and all outputs
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         byte_idx_q  <= '0;
         acc_q       <= '0;
         word_data_q <= '0;
         word_irq_q  <= 1'b0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         byte_idx_q  <= byte_idx_d;
         acc_q       <= acc_d;
         word_data_q <= word_data_d;
         word_irq_q  <= word_irq_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign word_irq     = word_irq_q;
   assign word_data    = word_data_q;
   assign word_pending = pending_q;
   assign overrun      = overrun_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx at DIV=16 (1.6 MHz clock, 100 kbaud).
module tb_spart_rx;

   localparam int CLK_HZ = 1_600_000;
   localparam int BAUD   = 100_000;
   localparam int DIV    = 16;
`ifdef SPART_PARITY_EN
   localparam int STOP_OFS = 171;
`else
   localparam int STOP_OFS = 155;
`endif

   logic        sys_clk  = 1'b0;
   logic        rst      = 1'b1;
   logic        rx       = 1'b1;
   logic        data_ack = 1'b0;
   logic        word_irq;
   logic [31:0] word_data;
   logic        word_pending;
   logic        overrun;
   logic        frame_err;

   int n_asserts = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int irq_cnt   = 0;
   int fe_cnt    = 0;
   int irq_cyc   = 0;
   int t_frame   = 0;

   spart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .rx           (rx),
      .data_ack     (data_ack),
      .word_irq     (word_irq),
      .word_data    (word_data),
      .word_pending (word_pending),
      .overrun      (overrun),
      .frame_err    (frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // pulse counters sampled mid-cycle
   always @(negedge sys_clk) begin
      if (word_irq) begin
         irq_cnt <= irq_cnt + 1;
         irq_cyc <= cyc;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit = 1'b1,
                             input logic ack_at_stop = 1'b0);
      t_frame = cyc;
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(DIV);
      end
`ifdef SPART_PARITY_EN
      rx = ^d;
      tick(DIV);
`endif
      rx = stop_bit;
      if (ack_at_stop) begin
         tick(10);
         data_ack = 1'b1;
         tick(1);
         data_ack = 1'b0;
         tick(5);
      end else begin
         tick(DIV);
      end
      rx = 1'b1;
      tick(20);
   endtask

   task automatic send_word(input logic [31:0] w, input logic ack_last = 1'b0);
      for (int i = 0; i < 4; i++)
         send_frame(w[8*i +: 8], 1'b1, (i == 3) && ack_last);
   endtask

   task automatic pulse_ack();
      data_ack = 1'b1;
      tick(1);
      data_ack = 1'b0;
      tick(2);
   endtask

`ifdef SPART_PARITY_EN
   task automatic send_par(input logic [7:0] d, input logic pbit);
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(DIV);
      end
      rx = pbit;
      tick(DIV);
      rx = 1'b1;
      tick(DIV + 20);
   endtask
`endif

   initial begin
      logic [7:0] part;
      part = 8'h5A;

      // reset state
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_word_data", word_data, 32'h0);
      chk("rst_word_irq", {31'h0, word_irq}, 32'h0);
      chk("rst_pending", {31'h0, word_pending}, 32'h0);
      chk("rst_overrun", {31'h0, overrun}, 32'h0);
      chk("rst_frame_err", {31'h0, frame_err}, 32'h0);

      // basic word and completion latency
      send_word(32'h1234_5678);
      chk("w1_irq_cnt", irq_cnt, 1);
      chk("w1_latency", irq_cyc - t_frame, STOP_OFS);
      chk("w1_data", word_data, 32'h1234_5678);
      chk("w1_pending", {31'h0, word_pending}, 32'h1);
      chk("w1_overrun", {31'h0, overrun}, 32'h0);
      chk("w1_fe_cnt", fe_cnt, 0);

      // partial word never visible
      send_frame(8'h11);
      chk("partial_data", word_data, 32'h1234_5678);
      chk("partial_irq_cnt", irq_cnt, 1);

      // ack clears pending; a second ack with nothing pending is harmless
      pulse_ack();
      chk("ack_pending", {31'h0, word_pending}, 32'h0);
      chk("ack_overrun", {31'h0, overrun}, 32'h0);
      pulse_ack();
      chk("ack2_pending", {31'h0, word_pending}, 32'h0);
      chk("ack2_data", word_data, 32'h1234_5678);

      // start-bit glitch mid-word leaves byte position alone
      send_frame(8'h22);
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(30);
      chk("glitch_fe_cnt", fe_cnt, 0);
      chk("glitch_irq_cnt", irq_cnt, 1);
      send_frame(8'h33);
      send_frame(8'h44);
      chk("w2_irq_cnt", irq_cnt, 2);
      chk("w2_data", word_data, 32'h4433_2211);
      pulse_ack();

      // bad stop bit discards the partial word
      send_frame(8'h99);
      send_frame(8'h88);
      send_frame(8'hAA, 1'b0);
      chk("fe_cnt", fe_cnt, 1);
      chk("fe_irq_cnt", irq_cnt, 2);
      send_word(32'h0403_0201);
      chk("w3_irq_cnt", irq_cnt, 3);
      chk("w3_data", word_data, 32'h0403_0201);
      chk("w3_overrun", {31'h0, overrun}, 32'h0);

      // ack coincident with completion: completion wins, no overrun
      send_word(32'hCAFE_F00D, 1'b1);
      chk("w4_irq_cnt", irq_cnt, 4);
      chk("w4_data", word_data, 32'hCAFE_F00D);
      chk("w4_pending", {31'h0, word_pending}, 32'h1);
      chk("w4_overrun", {31'h0, overrun}, 32'h0);

      // word while pending -> overrun, sticky through ack
      send_word(32'h8765_4321);
      chk("w5_irq_cnt", irq_cnt, 5);
      chk("w5_data", word_data, 32'h8765_4321);
      chk("w5_overrun", {31'h0, overrun}, 32'h1);
      pulse_ack();
      chk("w5_ack_pending", {31'h0, word_pending}, 32'h0);
      chk("w5_ack_overrun", {31'h0, overrun}, 32'h1);

      // reset during bit 4 of the second byte
      send_frame(8'h55);
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 4; i++) begin
         rx = part[i];
         tick(DIV);
      end
      rx = part[4];
      tick(5);
      rst = 1'b1;
      rx  = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid_rst_data", word_data, 32'h0);
      chk("mid_rst_irq", {31'h0, word_irq}, 32'h0);
      chk("mid_rst_pending", {31'h0, word_pending}, 32'h0);
      chk("mid_rst_overrun", {31'h0, overrun}, 32'h0);
      chk("mid_rst_frame_err", {31'h0, frame_err}, 32'h0);
      tick(20);
      send_word(32'hDEAD_BEEF);
      chk("w6_irq_cnt", irq_cnt, 6);
      chk("w6_data", word_data, 32'hDEAD_BEEF);
      chk("w6_pending", {31'h0, word_pending}, 32'h1);
      chk("w6_fe_cnt", fe_cnt, 1);

`ifdef SPART_PARITY_EN
      // 0x07 has three ones: even parity bit must be 1
      pulse_ack();
      send_par(8'h07, 1'b0);
      chk("par_bad_fe_cnt", fe_cnt, 2);
      chk("par_bad_irq_cnt", irq_cnt, 6);
      send_par(8'h07, 1'b1);
      send_frame(8'h00);
      send_frame(8'h00);
      send_frame(8'h00);
      chk("par_good_fe_cnt", fe_cnt, 2);
      chk("par_good_irq_cnt", irq_cnt, 7);
      chk("par_good_data", word_data, 32'h0000_0007);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
